// File: rtl/rf_alu_seq_if.sv
// Bundle of the command handshake and the register-file port signals that
// connect the ALU sequencer to its command source and to the 16x16 register file.
interface rf_alu_seq_if #(
  parameter int BW_DATA = 16,
  parameter int BW_ADDR = 4
);
  logic               i_cmd_valid;
  logic               o_cmd_ready;
  logic [2:0]         i_cmd_op;
  logic [BW_ADDR-1:0] i_cmd_rd;
  logic [BW_ADDR-1:0] i_cmd_rs0;
  logic [BW_ADDR-1:0] i_cmd_rs1;
  logic [BW_ADDR-1:0] o_rf_rd_addr0;
  logic [BW_ADDR-1:0] o_rf_rd_addr1;
  logic [BW_DATA-1:0] i_rf_rd_data0;
  logic [BW_DATA-1:0] i_rf_rd_data1;
  logic               o_rf_wr_en;
  logic [BW_ADDR-1:0] o_rf_wr_addr;
  logic [BW_DATA-1:0] o_rf_wr_data;
  logic               o_done;
  logic               o_zero;
  logic               o_carry;

  // Sequencer side
  modport slave (
    input  i_cmd_valid, i_cmd_op, i_cmd_rd, i_cmd_rs0, i_cmd_rs1,
    input  i_rf_rd_data0, i_rf_rd_data1,
    output o_cmd_ready, o_rf_rd_addr0, o_rf_rd_addr1,
    output o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data,
    output o_done, o_zero, o_carry
  );

  // Command source / register file side
  modport master (
    output i_cmd_valid, i_cmd_op, i_cmd_rd, i_cmd_rs0, i_cmd_rs1,
    output i_rf_rd_data0, i_rf_rd_data1,
    input  o_cmd_ready, o_rf_rd_addr0, o_rf_rd_addr1,
    input  o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data,
    input  o_done, o_zero, o_carry
  );
endinterface

// File: rtl/rf_alu_seq.sv
// Multi-cycle ALU sequencer in front of the register file: accepts one
// register-to-register command, reads both operands, computes, writes back.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a command; fields latched on valid
// READ  | read ports driven from latched rs0/rs1; operands captured
// EXEC  | ALU result and zero/carry flags registered
// WB    | write-back of result to latched rd, done pulse
module rf_alu_seq #(
  parameter int BW_DATA = 16,
  parameter int BW_ADDR = 4
) (
  input logic         i_clk,
  input logic         i_rstn,
  rf_alu_seq_if.slave bus
);
  localparam int BW_SH = $clog2(BW_DATA);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MOV = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q;
  logic [BW_ADDR-1:0] rd_q, rs0_q, rs1_q;
  logic [BW_DATA-1:0] opa_q, opb_q, result_q;
  logic               zero_q, carry_q;

  logic               accept;
  logic [BW_DATA:0]   sum, diff;
  logic [BW_SH-1:0]   shamt;
  logic [BW_DATA-1:0] alu_res;
  logic               alu_carry;

  assign accept = (state_q == IDLE) && bus.i_cmd_valid;

  // State register; reset aborts any in-flight command
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: fixed four-cycle walk once a command is accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_cmd_valid) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command fields are sampled only at acceptance and held until the next one
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      op_q  <= '0;
      rd_q  <= '0;
      rs0_q <= '0;
      rs1_q <= '0;
    end else if (accept) begin
      op_q  <= bus.i_cmd_op;
      rd_q  <= bus.i_cmd_rd;
      rs0_q <= bus.i_cmd_rs0;
      rs1_q <= bus.i_cmd_rs1;
    end
  end

  // Operand capture; happens before write-back so rd==rs sees the old value
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      opa_q <= '0;
      opb_q <= '0;
    end else if (state_q == READ) begin
      opa_q <= bus.i_rf_rd_data0;
      opb_q <= bus.i_rf_rd_data1;
    end
  end

  // ALU: results truncated to the datapath width, carry only for ADD/SUB
  always_comb begin
    sum       = {1'b0, opa_q} + {1'b0, opb_q};
    diff      = {1'b0, opa_q} - {1'b0, opb_q};
    shamt     = opb_q[BW_SH-1:0];
    alu_res   = opa_q;
    alu_carry = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res   = sum[BW_DATA-1:0];
        alu_carry = sum[BW_DATA];
      end
      OP_SUB: begin
        alu_res   = diff[BW_DATA-1:0];
        alu_carry = diff[BW_DATA];
      end
      OP_AND:  alu_res = opa_q & opb_q;
      OP_OR:   alu_res = opa_q | opb_q;
      OP_XOR:  alu_res = opa_q ^ opb_q;
      OP_SHL:  alu_res = opa_q << shamt;
      OP_SHR:  alu_res = opa_q >> shamt;
      OP_MOV:  alu_res = opa_q;
      default: alu_res = opa_q;
    endcase
  end

  // Result and flags register; flags hold until the next EXEC
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else if (state_q == EXEC) begin
      result_q <= alu_res;
      zero_q   <= (alu_res == '0);
      carry_q  <= alu_carry;
    end
  end

  assign bus.o_cmd_ready   = (state_q == IDLE);
  assign bus.o_rf_rd_addr0 = rs0_q;
  assign bus.o_rf_rd_addr1 = rs1_q;
  assign bus.o_rf_wr_en    = (state_q == WB);
  assign bus.o_rf_wr_addr  = rd_q;
  assign bus.o_rf_wr_data  = result_q;
  assign bus.o_done        = (state_q == WB);
  assign bus.o_zero        = zero_q;
  assign bus.o_carry       = carry_q;
endmodule
